// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch port: req/gnt request handshake plus rvalid response.
// The sequencer is the master, the memory is the slave.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns PCF, keeps at most one instruction-memory request in
// flight and fills the IF/ID register, with redirect flush, skid buffer and timeout.
//
//  state   | meaning
//  --------+----------------------------------------------------------------
//  REQ     | PCF ready, request presented when decode can take a result
//  WAIT    | request granted, waiting for rvalid
//  HOLD    | response parked in skid because decode is stalled
//  DISCARD | redirect arrived while a response was pending; drop it
//  ERR     | response timed out; sticky until reset
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    fetch_sequencer_if.master   imem,
    input  logic                PCSrcE,
    input  logic [31:0]         PCTargetE,
    input  logic                StallD,
    output logic [31:0]         InstrD,
    output logic [31:0]         PCD,
    output logic [31:0]         PCPlus4D,
    output logic                ValidD,
    output logic                FetchErr
);

    typedef enum logic [2:0] {
        ST_REQ     = 3'd0,
        ST_WAIT    = 3'd1,
        ST_HOLD    = 3'd2,
        ST_DISCARD = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      pcf;
    logic [31:0]      skid_instr;
    logic [31:0]      skid_pc;
    logic [CNT_W-1:0] cnt;

    logic redirect;
    logic in_flight;
    logic rsp;
    logic fire;
    logic cnt_last;
    logic load_mem;
    logic to_skid;
    logic load_skid;
    logic adv_pc;
    logic err_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_REQ: begin
                if (redirect)  state_next = ST_REQ;
                else if (fire) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect)      state_next = rsp ? ST_REQ : ST_DISCARD;
                else if (rsp)      state_next = to_skid ? ST_HOLD : ST_REQ;
                else if (cnt_last) state_next = ST_ERR;
            end
            ST_HOLD: begin
                if (redirect || !StallD) state_next = ST_REQ;
            end
            ST_DISCARD: begin
                // the stale response retires the request even if a new redirect lands with it
                if (rsp)           state_next = ST_REQ;
                else if (redirect) state_next = ST_DISCARD;
                else if (cnt_last) state_next = ST_ERR;
            end
            ST_ERR:  state_next = ST_ERR;
            default: state_next = ST_REQ;
        endcase
    end

    always_comb begin
        // rst gating keeps the request low for the whole time reset is held
        imem.imem_req  = rst && (state == ST_REQ) && !PCSrcE && !(ValidD && StallD);
        imem.imem_addr = pcf;

        redirect  = PCSrcE && (state != ST_ERR);
        in_flight = (state == ST_WAIT) || (state == ST_DISCARD);
        rsp       = imem.imem_rvalid && in_flight;
        fire      = imem.imem_req && imem.imem_gnt;
        cnt_last  = (cnt == CNT_W'(TIMEOUT - 1));
        adv_pc    = (state == ST_WAIT) && rsp && !redirect;
        load_mem  = adv_pc && (!ValidD || !StallD);
        to_skid   = adv_pc && ValidD && StallD;
        load_skid = (state == ST_HOLD) && !redirect && !StallD;
        err_set   = in_flight && !rsp && !redirect && cnt_last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcf        <= RESET_PC;
            cnt        <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
            FetchErr   <= 1'b0;
        end else begin
            if (redirect) begin
                pcf <= PCTargetE & ~32'h3;
            end else if (adv_pc) begin
                pcf <= pcf + 32'd4;
            end

            // a redirect restarts the timeout for whatever response is still owed
            if (redirect || fire) begin
                cnt <= '0;
            end else if (in_flight && !rsp) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (redirect) begin
                skid_instr <= '0;
                skid_pc    <= '0;
            end else if (to_skid) begin
                skid_instr <= imem.imem_rdata;
                skid_pc    <= pcf;
            end

            if (err_set) begin
                FetchErr <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            InstrD   <= '0;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (state == ST_ERR) begin
            ValidD <= 1'b0;
        end else if (redirect) begin
            InstrD   <= '0;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (load_mem) begin
            InstrD   <= imem.imem_rdata;
            PCD      <= pcf;
            PCPlus4D <= pcf + 32'd4;
            ValidD   <= 1'b1;
        end else if (load_skid) begin
            InstrD   <= skid_instr;
            PCD      <= skid_pc;
            PCPlus4D <= skid_pc + 32'd4;
            ValidD   <= 1'b1;
        end else if (!StallD) begin
            ValidD <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic checked against
// a program-order model (decode must see PC, PC+4, ... restarting at each redirect target).
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        FetchErr;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .RESET_PC (RESET_PC),
        .TIMEOUT  (16),
        .CNT_W    (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem      (bus),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .StallD    (StallD),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD),
        .FetchErr  (FetchErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // memory image and program-order model
    logic [31:0] exp_pc;
    int          n_cons;
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    logic [31:0] grant_q[$];
    logic        vd_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b0;
        PCSrcE           = 1'b0;
        PCTargetE        = '0;
        StallD           = 1'b0;
        bus.imem_gnt     = 1'b0;
        bus.imem_rvalid  = 1'b0;
        bus.imem_rdata   = '0;
        pend             = 1'b0;
        pend_cnt         = 0;
        pend_addr        = '0;
        exp_pc           = RESET_PC;
        n_cons           = 0;
        grant_q.delete();
        vd_log.delete();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_req",      {31'd0, bus.imem_req}, 32'd0);
        check_val("rst_addr",     bus.imem_addr, RESET_PC);
        check_val("rst_valid",    {31'd0, ValidD}, 32'd0);
        check_val("rst_instr",    InstrD, 32'd0);
        check_val("rst_pcd",      PCD, 32'd0);
        check_val("rst_pcplus4",  PCPlus4D, 32'd0);
        check_val("rst_err",      {31'd0, FetchErr}, 32'd0);
        rst = 1'b1;
        #1;
        check_val("first_req",    {31'd0, bus.imem_req}, 32'd1);
        check_val("first_addr",   bus.imem_addr, RESET_PC);
    endtask

    // one cycle per iteration: drive after the rising edge, evaluate at the falling edge
    task automatic run_random(input int n, input int p_stall, input int p_redir,
                              input int p_gnt, input int max_lat);
        logic busy;
        for (int c = 0; c < n; c++) begin
            StallD          = ($urandom_range(99) < p_stall);
            PCSrcE          = ($urandom_range(99) < p_redir);
            PCTargetE       = $urandom;
            bus.imem_gnt    = ($urandom_range(99) < p_gnt);
            bus.imem_rvalid = pend && (pend_cnt == 0);
            bus.imem_rdata  = pend ? mem_word(pend_addr) : $urandom;
            @(negedge clk);
            vd_log.push_back(ValidD);
            if (ValidD && !StallD) begin
                check_val("cons_pc",      PCD, exp_pc);
                check_val("cons_instr",   InstrD, mem_word(exp_pc));
                check_val("cons_pcplus4", PCPlus4D, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                n_cons++;
            end
            busy = pend;
            if (bus.imem_rvalid) pend = 1'b0;
            else if (pend)       pend_cnt--;
            if (bus.imem_req && bus.imem_gnt) begin
                check_val("one_outstanding", {31'd0, busy}, 32'd0);
                check_val("addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
                grant_q.push_back(bus.imem_addr);
                pend      = 1'b1;
                pend_addr = bus.imem_addr;
                pend_cnt  = $urandom_range(max_lat - 1, 0);
            end
            if (PCSrcE) exp_pc = PCTargetE & ~32'h3;
            @(posedge clk);
            #1;
        end
        bus.imem_rvalid = 1'b0;
        PCSrcE          = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // back-to-back fetch, one instruction every two cycles
        do_reset();
        run_random(8, 0, 0, 100, 1);
        check_val("t1_grant0", grant_q[0], 32'h0);
        check_val("t1_grant1", grant_q[1], 32'h4);
        check_val("t1_grant2", grant_q[2], 32'h8);
        check_val("t1_count",  n_cons, 3);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("t1_valid_c%0d", i), {31'd0, vd_log[i]}, (i == 2 || i == 4) ? 32'd1 : 32'd0);
        end

        // decode stall holds IF/ID and blocks new requests, then random stall traffic
        do_reset();
        run_random(4, 0, 0, 100, 1);
        StallD       = 1'b1;
        bus.imem_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("t2_req_blocked", {31'd0, bus.imem_req}, 32'd0);
            tick();
            check_val("t2_hold_valid", {31'd0, ValidD}, 32'd1);
            check_val("t2_hold_instr", InstrD, 32'h1);
            check_val("t2_hold_pcd",   PCD, 32'h4);
            check_val("t2_hold_pc4",   PCPlus4D, 32'h8);
        end
        StallD = 1'b0;
        run_random(300, 40, 0, 70, 4);
        check_val("t2_progress", {31'd0, n_cons >= 20}, 32'd1);

        // redirect while a response is pending
        do_reset();
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        PCSrcE       = 1'b1;
        PCTargetE    = 32'h0000_0103;
        #1;
        check_val("t3_no_req_redirect", {31'd0, bus.imem_req}, 32'd0);
        tick();
        PCSrcE          = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        #1;
        check_val("t3_flush_valid", {31'd0, ValidD}, 32'd0);
        check_val("t3_flush_instr", InstrD, 32'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        #1;
        check_val("t3_stale_dropped", {31'd0, ValidD}, 32'd0);
        check_val("t3_stale_instr",   InstrD, 32'd0);
        check_val("t3_req",           {31'd0, bus.imem_req}, 32'd1);
        check_val("t3_addr",          bus.imem_addr, 32'h0000_0100);
        exp_pc = 32'h0000_0100;
        n_cons = 0;
        grant_q.delete();
        run_random(6, 0, 0, 100, 1);
        check_val("t3_grant", grant_q[0], 32'h0000_0100);
        check_val("t3_count", n_cons, 2);

        // flush beats stall
        do_reset();
        run_random(4, 0, 0, 100, 1);
        check_val("t4_setup_valid", {31'd0, ValidD}, 32'd1);
        StallD       = 1'b1;
        PCSrcE       = 1'b1;
        PCTargetE    = 32'h0000_0200;
        bus.imem_gnt = 1'b1;
        #1;
        check_val("t4_req", {31'd0, bus.imem_req}, 32'd0);
        tick();
        PCSrcE = 1'b0;
        StallD = 1'b0;
        #1;
        check_val("t4_valid",   {31'd0, ValidD}, 32'd0);
        check_val("t4_instr",   InstrD, 32'd0);
        check_val("t4_pcd",     PCD, 32'd0);
        check_val("t4_pcplus4", PCPlus4D, 32'd0);
        check_val("t4_addr",    bus.imem_addr, 32'h0000_0200);
        check_val("t4_req_new", {31'd0, bus.imem_req}, 32'd1);

        // response timeout: error on the 16th silent cycle after the grant
        do_reset();
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        repeat (15) tick();
        check_val("t5_no_err_early", {31'd0, FetchErr}, 32'd0);
        tick();
        check_val("t5_err",     {31'd0, FetchErr}, 32'd1);
        check_val("t5_req_off", {31'd0, bus.imem_req}, 32'd0);
        PCSrcE          = 1'b1;
        PCTargetE       = 32'h0000_0300;
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1234_5678;
        repeat (3) tick();
        check_val("t5_err_sticky", {31'd0, FetchErr}, 32'd1);
        check_val("t5_err_req",    {31'd0, bus.imem_req}, 32'd0);
        check_val("t5_err_addr",   bus.imem_addr, 32'd0);
        check_val("t5_err_valid",  {31'd0, ValidD}, 32'd0);

        // asynchronous reset in the middle of a pending request
        do_reset();
        run_random(4, 0, 0, 100, 1);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        check_val("t6_setup_instr", InstrD, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check_val("t6_instr",   InstrD, 32'd0);
        check_val("t6_pcd",     PCD, 32'd0);
        check_val("t6_pcplus4", PCPlus4D, 32'd0);
        check_val("t6_valid",   {31'd0, ValidD}, 32'd0);
        check_val("t6_req",     {31'd0, bus.imem_req}, 32'd0);
        check_val("t6_addr",    bus.imem_addr, 32'd0);
        check_val("t6_err",     {31'd0, FetchErr}, 32'd0);

        // mixed random traffic: stalls, redirects, gnt gaps, variable latency
        do_reset();
        run_random(3000, 30, 5, 70, 5);
        check_val("rand_no_err",   {31'd0, FetchErr}, 32'd0);
        check_val("rand_progress", {31'd0, n_cons >= 200}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
